// File: rtl/ssm_master_ctrl.sv
// ssm_master_ctrl: host request/response front end for the a2rtap target bus.
// Takes one host request at a time and runs it as a single bus strobe.
// The strobe is released when the target signals ready, or when the access
// has been waiting too long. The result goes back to the host as a
// response, and a saturating counter records failed accesses.
//
//   state  | meaning
//   IDLE   | ready for a host request; req_ready is high
//   ACCESS | bus strobe high, waiting for target ready or for the timeout
//   RESP   | response presented, waiting for host rsp_ready
module ssm_master_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8,
    parameter int ERRCNT_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   a2rtap_master_ifc_address,
    output logic [DATA_WIDTH-1:0]   a2rtap_master_ifc_write_data,
    output logic                    a2rtap_master_ifc_read,
    output logic                    a2rtap_master_ifc_write,
    input  logic [DATA_WIDTH-1:0]   a2rtap_master_ifc_read_data,
    input  logic                    a2rtap_master_ifc_ready,
    input  logic                    a2rtap_master_ifc_error,
    input  logic                    err_clr,
    output logic [ERRCNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // The timer holds the number of strobe cycles already spent without a
    // ready. The access expires in the cycle where that count reaches
    // TIMEOUT_CYCLES-1, so the strobe is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [TO_WIDTH-1:0]     timer_q, timer_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    timeout_q, timeout_d;
    logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                    err_inc;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            timer_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic: latch the request, run the bus access, hold the response.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    timer_d = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // If ready arrives in the expiry cycle, the target's answer is used.
                if (a2rtap_master_ifc_ready) begin
                    rdata_d   = write_q ? '0 : a2rtap_master_ifc_read_data;
                    error_d   = a2rtap_master_ifc_error;
                    timeout_d = 1'b0;
                    err_inc   = a2rtap_master_ifc_error;
                    state_d   = ST_RESP;
                end else begin
                    timer_d = timer_q + TO_WIDTH'(1);
                    if ((TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST)) begin
                        rdata_d   = '0;
                        error_d   = 1'b1;
                        timeout_d = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error counter: saturates at all-ones; a clear beats a same-cycle increment.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_WIDTH'(1);
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        req_ready                    = (state_q == ST_IDLE);
        rsp_valid                    = (state_q == ST_RESP);
        rsp_rdata                    = rdata_q;
        rsp_error                    = error_q;
        rsp_timeout                  = timeout_q;
        a2rtap_master_ifc_address    = addr_q;
        a2rtap_master_ifc_write_data = wdata_q;
        a2rtap_master_ifc_read       = (state_q == ST_ACCESS) && !write_q;
        a2rtap_master_ifc_write      = (state_q == ST_ACCESS) && write_q;
        err_count                    = err_count_q;
    end

endmodule

// File: tb/tb_ssm_master_ctrl.sv
// Directed bench for ssm_master_ctrl with a response scoreboard and a
// scripted bus target.
module tb_ssm_master_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] t_rdata = '0;
    logic        t_ready = 1'b0;
    logic        t_error = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  err_count;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ssm_master_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4),
        .TO_WIDTH(3), .ERRCNT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .a2rtap_master_ifc_address(bus_addr),
        .a2rtap_master_ifc_write_data(bus_wdata),
        .a2rtap_master_ifc_read(bus_read),
        .a2rtap_master_ifc_write(bus_write),
        .a2rtap_master_ifc_read_data(t_rdata),
        .a2rtap_master_ifc_ready(t_ready),
        .a2rtap_master_ifc_error(t_error),
        .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // delay: strobe cycles before ready (0 = first strobe cycle), -1 = never ready.
    task automatic run_access(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                              input int delay, input logic [31:0] trd, input logic terr,
                              input int exp_strobe, input int rsp_wait, input logic clr,
                              input logic [1:0] exp_err);
        rsp_t e;
        int   n;
        @(negedge clk);
        err_clr = clr;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        e.timeout = (delay < 0);
        e.error   = (delay < 0) || terr;
        e.rdata   = ((delay < 0) || wr) ? 32'h0 : trd;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~wd;
        n = 0;
        while ((bus_read || bus_write) && n < 16) begin
            chk("bus_addr", bus_addr, addr);
            chk("bus_read", bus_read, !wr);
            chk("bus_write", bus_write, wr);
            if (wr) chk("bus_wdata", bus_wdata, wd);
            if (n == delay) begin
                t_ready = 1'b1;
                t_error = terr;
                t_rdata = trd;
            end
            @(negedge clk);
            t_ready = 1'b0;
            t_error = 1'b0;
            t_rdata = $urandom;
            n++;
        end
        chk("strobe_cycles", n, exp_strobe);
        chk("rsp_valid_set", rsp_valid, 1);
        if (rsp_wait > 0) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 8'h5A;
        end
        for (int i = 0; i < rsp_wait; i++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_rdata", rsp_rdata, exp_q[0].rdata);
            chk("hold_error", rsp_error, exp_q[0].error);
            chk("hold_no_strobe", bus_read | bus_write, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", rsp_error, e.error);
        chk("rsp_timeout", rsp_timeout, e.timeout);
        chk("err_count", err_count, exp_err);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        chk("rsp_valid_clr", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        chk("no_strobe_after", bus_read | bus_write, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0 + 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strobes", bus_read | bus_write, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b0;

        // write, target ready on first strobe cycle
        run_access(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'hFFFF0000, 1'b0, 1, 0, 1'b0, 2'd0);
        // read, ready on the 4th strobe cycle (also the expiry cycle: ready wins)
        run_access(1'b0, 8'h22, 32'h0, 3, 32'h12345678, 1'b0, 4, 0, 1'b0, 2'd0);
        // read, never ready -> timeout after 4 strobe cycles
        run_access(1'b0, 8'h33, 32'h0, -1, 32'h0, 1'b0, 4, 0, 1'b0, 2'd1);
        // response held 5 cycles with a pending request
        run_access(1'b1, 8'h44, 32'hCAFEF00D, 1, 32'h0, 1'b0, 2, 5, 1'b0, 2'd1);

        // ready/error with no strobe are ignored
        @(negedge clk);
        t_ready = 1'b1;
        t_error = 1'b1;
        @(negedge clk);
        t_ready = 1'b0;
        t_error = 1'b0;
        chk("idle_ignore_valid", rsp_valid, 0);
        chk("idle_ignore_errcnt", err_count, 1);
        chk("idle_ignore_ready", req_ready, 1);

        // reset in the middle of an access
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h66;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_read", bus_read, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_read", bus_read, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_errcnt", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        run_access(1'b0, 8'h77, 32'h0, 0, 32'hA5A55A5A, 1'b0, 1, 0, 1'b0, 2'd0);

        // saturating error counter, then clear colliding with an increment
        run_access(1'b1, 8'h80, 32'h1, 0, 32'h0, 1'b1, 1, 0, 1'b0, 2'd1);
        run_access(1'b0, 8'h81, 32'h0, 0, 32'h11, 1'b1, 1, 0, 1'b0, 2'd2);
        run_access(1'b0, 8'h82, 32'h0, 2, 32'h22, 1'b1, 3, 0, 1'b0, 2'd3);
        run_access(1'b1, 8'h83, 32'h2, 0, 32'h0, 1'b1, 1, 0, 1'b0, 2'd3);
        run_access(1'b0, 8'h84, 32'h0, 0, 32'h44, 1'b1, 1, 0, 1'b0, 2'd3);
        run_access(1'b0, 8'h85, 32'h0, 0, 32'h55, 1'b1, 1, 0, 1'b1, 2'd0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
